cellrv32_npu_instruction_issuer: RTL and testbench

CELLRV32_NPU_INSTRUCTION_ISSUER -- requirements
Module: cellrv32_npu_instruction_issuer

---
 rtl/cellrv32_npu_package.sv | 19 +
 rtl/cellrv32_npu_inst_fifo.sv | 56 +++++
 rtl/cellrv32_npu_instruction_issuer.sv | 99 +++++++++
 tb/tb_cellrv32_npu_instruction_issuer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_npu_package.sv
// Shared NPU types: instruction word layout and opcode constants.
package cellrv32_npu_package;

  localparam int OP_CODE_WIDTH = 6;

  localparam logic [OP_CODE_WIDTH-1:0] OPCODE_NOP    = 6'h00;
  localparam logic [OP_CODE_WIDTH-1:0] OPCODE_LOAD   = 6'h08;
  localparam logic [OP_CODE_WIDTH-1:0] OPCODE_MATMUL = 6'h20;
  localparam logic [OP_CODE_WIDTH-1:0] OPCODE_STORE  = 6'h28;

  // 32-bit instruction word: opcode, source/destination scratchpad address, length
  typedef struct packed {
    logic [OP_CODE_WIDTH-1:0] op_code;
    logic [9:0]               src_addr;
    logic [9:0]               dst_addr;
    logic [5:0]               len;
  } instruction_t;

endpackage

// File: rtl/cellrv32_npu_inst_fifo.sv
// Instruction FIFO: circular storage with read/write pointers and an occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module cellrv32_npu_inst_fifo
  import cellrv32_npu_package::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  instruction_t             wdata_i,
  output instruction_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   ONE  = {{AW{1'b0}}, 1'b1};

  instruction_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;

  // Storage array is not reset; only pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping, explicit wrap at the last slot
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem[rd_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/cellrv32_npu_instruction_issuer.sv
// Instruction issuer: buffers host-pushed instructions and hands them one per
// cycle to the look-ahead buffer whenever the NPU is enabled and not busy.
module cellrv32_npu_instruction_issuer
  import cellrv32_npu_package::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          enable_i,
  input  logic                          inst_busy_i,
  input  instruction_t                  host_inst_i,
  input  logic                          host_we_i,
  input  logic                          flush_i,
  input  logic                          clr_err_i,
  output logic                          host_full_o,
  output logic                          host_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   host_level_o,
  output logic                          overflow_o,
  output instruction_t                  inst_o,
  output logic                          inst_wr_o,
  output logic [CNT_WIDTH-1:0]          issued_cnt_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [LW-1:0] level;
  instruction_t  head;
  logic          full;
  logic          empty;
  logic          issue_en;
  logic          push;
  logic          pop;
  logic          overflow_evt;

  // Status comes straight from the registered count, so host_we_i never
  // reaches the flags combinationally; a push into an empty FIFO therefore
  // cannot be popped on the same edge.
  assign full         = (level == LW'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign issue_en     = enable_i & ~inst_busy_i;
  assign push         = host_we_i & ~full & ~flush_i;
  assign pop          = issue_en & ~empty & ~flush_i;
  assign overflow_evt = host_we_i & full & ~flush_i;

  cellrv32_npu_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (host_inst_i),
    .rdata_o (head),
    .count_o (level)
  );

  // Issue register: follows the consumer's stall gating, flush overrides it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inst_o    <= '0;
      inst_wr_o <= 1'b0;
    end else if (flush_i) begin
      inst_o    <= '0;
      inst_wr_o <= 1'b0;
    end else if (issue_en) begin
      if (!empty) begin
        inst_o    <= head;
        inst_wr_o <= 1'b1;
      end else begin
        inst_o    <= '0;
        inst_wr_o <= 1'b0;
      end
    end
  end

  // Issued-instruction counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  issued_cnt_o <= '0;
    else if (pop) issued_cnt_o <= issued_cnt_o + CNT_WIDTH'(1);
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear; flush leaves it alone
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o <= 1'b0;
    end else if (!flush_i) begin
      if (overflow_evt)   overflow_o <= 1'b1;
      else if (clr_err_i) overflow_o <= 1'b0;
    end
  end

  assign host_full_o  = full;
  assign host_empty_o = empty;
  assign host_level_o = level;

endmodule

// File: tb/tb_cellrv32_npu_instruction_issuer.sv
// Bench for the instruction issuer: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the issuer's behaviour.
module tb_cellrv32_npu_instruction_issuer;
  import cellrv32_npu_package::*;

  localparam int D  = 16;
  localparam int CW = 32;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              enable_i;
  logic              inst_busy_i;
  instruction_t      host_inst_i;
  logic              host_we_i;
  logic              flush_i;
  logic              clr_err_i;
  logic              host_full_o;
  logic              host_empty_o;
  logic [$clog2(D):0] host_level_o;
  logic              overflow_o;
  instruction_t      inst_o;
  logic              inst_wr_o;
  logic [CW-1:0]     issued_cnt_o;

  cellrv32_npu_instruction_issuer #(
    .FIFO_DEPTH (D),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .enable_i     (enable_i),
    .inst_busy_i  (inst_busy_i),
    .host_inst_i  (host_inst_i),
    .host_we_i    (host_we_i),
    .flush_i      (flush_i),
    .clr_err_i    (clr_err_i),
    .host_full_o  (host_full_o),
    .host_empty_o (host_empty_o),
    .host_level_o (host_level_o),
    .overflow_o   (overflow_o),
    .inst_o       (inst_o),
    .inst_wr_o    (inst_wr_o),
    .issued_cnt_o (issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  instruction_t  model_q[$];
  instruction_t  m_inst;
  logic          m_wr;
  logic [CW-1:0] m_cnt;
  logic          m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ":level"},    64'(host_level_o), 64'(sz));
    check({tag, ":full"},     64'(host_full_o),  64'(sz == D));
    check({tag, ":empty"},    64'(host_empty_o), 64'(sz == 0));
    check({tag, ":overflow"}, 64'(overflow_o),   64'(m_ovf));
    check({tag, ":inst"},     64'(inst_o),       64'(m_inst));
    check({tag, ":inst_wr"},  64'(inst_wr_o),    64'(m_wr));
    check({tag, ":cnt"},      64'(issued_cnt_o), 64'(m_cnt));
  endtask

  task automatic model_reset();
    model_q.delete();
    m_inst = '0;
    m_wr   = 1'b0;
    m_cnt  = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the same edge, compare after it
  task automatic step(input logic we, input instruction_t ins, input logic en,
                      input logic busy, input logic fl, input logic clr, input string tag);
    logic was_full;
    host_we_i   = we;
    host_inst_i = ins;
    enable_i    = en;
    inst_busy_i = busy;
    flush_i     = fl;
    clr_err_i   = clr;
    @(posedge clk_i);
    was_full = (model_q.size() == D);
    if (fl) begin
      model_q.delete();
      m_inst = '0;
      m_wr   = 1'b0;
    end else begin
      if (en && !busy) begin
        if (model_q.size() > 0) begin
          m_inst = model_q.pop_front();
          m_wr   = 1'b1;
          m_cnt  = m_cnt + 1;
        end else begin
          m_inst = '0;
          m_wr   = 1'b0;
        end
      end
      if (we && !was_full) model_q.push_back(ins);
      if (we && was_full)  m_ovf = 1'b1;
      else if (clr)        m_ovf = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  function automatic instruction_t mk(input logic [OP_CODE_WIDTH-1:0] op);
    instruction_t t;
    t = instruction_t'($urandom);
    t.op_code = op;
    return t;
  endfunction

  function automatic instruction_t rnd_inst();
    return instruction_t'($urandom);
  endfunction

  initial begin
    rstn_i      = 1'b0;
    enable_i    = 1'b0;
    inst_busy_i = 1'b0;
    host_inst_i = '0;
    host_we_i   = 1'b0;
    flush_i     = 1'b0;
    clr_err_i   = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rstn_i = 1'b1;
    #2;

    // Three pushes issue back to back, two cycles after the first push
    step(1, mk(OPCODE_LOAD),   1, 0, 0, 0, "seq_push0");
    check("seq_no_same_edge_pop", 64'(inst_wr_o), 64'd0);
    step(1, mk(OPCODE_MATMUL), 1, 0, 0, 0, "seq_push1");
    check("seq_first_op", 64'(inst_o.op_code), 64'(OPCODE_LOAD));
    step(1, mk(OPCODE_STORE),  1, 0, 0, 0, "seq_push2");
    check("seq_second_op", 64'(inst_o.op_code), 64'(OPCODE_MATMUL));
    step(0, '0, 1, 0, 0, 0, "seq_drain0");
    check("seq_third_op", 64'(inst_o.op_code), 64'(OPCODE_STORE));
    step(0, '0, 1, 0, 0, 0, "seq_drain1");
    check("seq_cnt3", 64'(issued_cnt_o), 64'd3);

    // Busy freezes the issue stage while an instruction is presented
    step(1, rnd_inst(), 1, 0, 0, 0, "busy_push0");
    step(1, rnd_inst(), 1, 0, 0, 0, "busy_push1");
    for (int i = 0; i < 5; i++) step(0, '0, 1, 1, 0, 0, "busy_hold");
    check("busy_level_held", 64'(host_level_o), 64'd1);
    step(0, '0, 1, 0, 0, 0, "busy_release");
    step(0, '0, 1, 0, 0, 0, "busy_drain");

    // Disabled: fill to full, then one more push overflows; clear the flag
    for (int i = 0; i < D; i++) step(1, rnd_inst(), 0, 0, 0, 0, "fill");
    step(1, rnd_inst(), 0, 0, 0, 0, "fill_over");
    check("full_level16", 64'(host_level_o), 64'(D));
    check("full_ovf", 64'(overflow_o), 64'd1);
    step(0, '0, 0, 0, 0, 1, "clr_err");
    check("clr_ovf", 64'(overflow_o), 64'd0);

    // Full with a pop in the same cycle: push still dropped
    step(1, rnd_inst(), 1, 0, 0, 0, "full_push_pop");
    check("full_pop_level15", 64'(host_level_o), 64'(D - 1));
    check("full_pop_ovf", 64'(overflow_o), 64'd1);
    step(0, '0, 1, 0, 0, 1, "clr_err2");

    // Flush with five queued and a concurrent push
    step(0, '0, 0, 0, 1, 0, "pre_flush");
    for (int i = 0; i < 5; i++) step(1, rnd_inst(), 0, 0, 0, 0, "q5");
    step(1, rnd_inst(), 1, 0, 1, 0, "flush_with_push");
    check("flush_level0", 64'(host_level_o), 64'd0);
    step(0, '0, 1, 0, 0, 0, "post_flush");

    // Asynchronous reset with four queued and an instruction presented
    for (int i = 0; i < 5; i++) step(1, rnd_inst(), 0, 0, 0, 0, "q5b");
    step(0, '0, 1, 0, 0, 0, "present");
    host_we_i = 1'b0;
    enable_i  = 1'b1;
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk_i);
    #1;
    check_all("in_reset");
    #3;
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0, "after_reset_idle");

    // Randomized traffic in phases with different pressure
    for (int ph = 0; ph < 6; ph++) begin
      int we_pct, en_pct, busy_pct;
      we_pct   = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 50 : 25);
      en_pct   = (ph % 2 == 0) ? 40 : 90;
      busy_pct = 20;
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(99) < we_pct, rnd_inst(),
             $urandom_range(99) < en_pct, $urandom_range(99) < busy_pct,
             $urandom_range(99) < 2, $urandom_range(99) < 5, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
